// File: rtl/ram_dp_clr.sv
// Dual-port RAM: port A read/write, port B read-only, with a clear engine
// that sweeps FILL into every word after reset and on request.
module ram_dp_clr #(
  parameter int                       ADDRWIDTH    = 12,
  parameter int                       DATAWIDTH    = 8,
  parameter logic [DATAWIDTH-1:0]     FILL         = '0,
  parameter int                       CLR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDRWIDTH-1:0] a_addr,
  input  logic [DATAWIDTH-1:0] a_din,
  input  logic                 a_wr_n,
  input  logic                 a_ce_n,
  output logic [DATAWIDTH-1:0] a_q,
  input  logic [ADDRWIDTH-1:0] b_addr,
  input  logic                 b_ce_n,
  output logic [DATAWIDTH-1:0] b_q,
  input  logic                 clr_req,
  output logic                 busy
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic [DATAWIDTH-1:0]   a_data_q, b_data_q;

  logic                   mem_we;
  logic [ADDRWIDTH-1:0]   mem_waddr;
  logic [DATAWIDTH-1:0]   mem_wdata;
  logic [DATAWIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= (CLR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Clear engine owns the write port while sweeping; reset suppresses all writes.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_waddr  = a_addr;
    mem_wdata  = a_din;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (!a_ce_n && !a_wr_n) begin
          mem_we = reset_n;
        end
      end
      S_CLEAR: begin
        mem_we     = reset_n;
        mem_waddr  = clr_addr_q;
        mem_wdata  = FILL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDRWIDTH{1'b1}}) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read registers see the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_data_q <= mem[a_addr];
      b_data_q <= mem[b_addr];
    end
  end

  assign a_q  = a_ce_n ? '0 : a_data_q;
  assign b_q  = b_ce_n ? '0 : b_data_q;
  assign busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: reference model compared every cycle,
// plus directed literal checks; a second instance covers CLR_ON_RESET=0.
module tb_ram_dp_clr;

  localparam logic [7:0] FILLV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n, a_wr_n, a_ce_n, b_ce_n, clr_req, busy;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_din, a_q, b_q;

  logic       r0_reset_n, r0_a_wr_n, r0_a_ce_n, r0_b_ce_n, r0_clr_req, r0_busy;
  logic [3:0] r0_a_addr, r0_b_addr;
  logic [7:0] r0_a_din, r0_a_q, r0_b_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_dp_clr #(.ADDRWIDTH(4), .DATAWIDTH(8), .FILL(FILLV), .CLR_ON_RESET(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .a_addr(a_addr), .a_din(a_din), .a_wr_n(a_wr_n), .a_ce_n(a_ce_n), .a_q(a_q),
    .b_addr(b_addr), .b_ce_n(b_ce_n), .b_q(b_q),
    .clr_req(clr_req), .busy(busy)
  );

  ram_dp_clr #(.ADDRWIDTH(4), .DATAWIDTH(8), .FILL(FILLV), .CLR_ON_RESET(0)) u_dut_nr (
    .clk(clk), .reset_n(r0_reset_n),
    .a_addr(r0_a_addr), .a_din(r0_a_din), .a_wr_n(r0_a_wr_n), .a_ce_n(r0_a_ce_n), .a_q(r0_a_q),
    .b_addr(r0_b_addr), .b_ce_n(r0_b_ce_n), .b_q(r0_b_q),
    .clr_req(r0_clr_req), .busy(r0_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word array plus a count of words still to be cleared.
  logic [7:0] m_mem [16];
  bit         m_kn  [16];
  int         sweep_left = 0;
  int         sweep_pos  = 0;
  logic [7:0] exp_a = '0, exp_b = '0;
  bit         kn_a = 0, kn_b = 0, started = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_a = '0; exp_b = '0; kn_a = 1; kn_b = 1;
      sweep_left = 16; sweep_pos = 0; started = 1;
    end else begin
      exp_a = m_mem[a_addr]; kn_a = m_kn[a_addr];
      exp_b = m_mem[b_addr]; kn_b = m_kn[b_addr];
      if (sweep_left > 0) begin
        m_mem[sweep_pos] = FILLV; m_kn[sweep_pos] = 1;
        sweep_pos++; sweep_left--;
      end else if (clr_req) begin
        sweep_left = 16; sweep_pos = 0;
      end else if (!a_ce_n && !a_wr_n) begin
        m_mem[a_addr] = a_din; m_kn[a_addr] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_busy", 32'(busy), 32'(sweep_left > 0));
      if (a_ce_n) check("model_a_q_gated", 32'(a_q), 32'h0);
      else if (kn_a) check("model_a_q", 32'(a_q), 32'(exp_a));
      if (b_ce_n) check("model_b_q_gated", 32'(b_q), 32'h0);
      else if (kn_b) check("model_b_q", 32'(b_q), 32'(exp_b));
    end
  end

  task automatic idle_inputs();
    a_wr_n = 1; a_ce_n = 1; b_ce_n = 1; clr_req = 0; a_din = '0;
  endtask

  initial begin
    int cnt;
    reset_n = 0; a_addr = '0; b_addr = '0; idle_inputs();
    r0_reset_n = 0; r0_a_addr = '0; r0_b_addr = '0; r0_a_din = '0;
    r0_a_wr_n = 1; r0_a_ce_n = 1; r0_b_ce_n = 1; r0_clr_req = 0;

    // Reset clear sweep
    tick(); tick();
    check("reset_busy", 32'(busy), 32'h1);
    check("reset_a_q", 32'(a_q), 32'h0);
    reset_n = 1;
    for (cnt = 0; busy && cnt < 40; cnt++) tick();
    check("reset_sweep_len", 32'(cnt), 32'd16);

    a_ce_n = 0; b_ce_n = 0;
    for (int i = 0; i < 16; i++) begin
      a_addr = 4'(i); b_addr = 4'(15 - i);
      tick();
      check("clear_a", 32'(a_q), 32'(FILLV));
      check("clear_b", 32'(b_q), 32'(FILLV));
    end

    // Basic write/read
    a_addr = 4'd7; a_din = 8'h3C; a_wr_n = 0;
    tick();
    a_wr_n = 1; b_addr = 4'd7;
    tick();
    check("wr_rd_a", 32'(a_q), 32'h3C);
    check("wr_rd_b", 32'(b_q), 32'h3C);
    a_ce_n = 1; #1;
    check("a_ce_gate_7", 32'(a_q), 32'h0);
    a_addr = 4'd3; tick();
    check("a_ce_gate_3", 32'(a_q), 32'h0);

    // Collision
    a_ce_n = 0; a_addr = 4'd2; a_din = 8'h55; a_wr_n = 0; b_addr = 4'd2;
    tick();
    check("collide_old", 32'(b_q), 32'hA5);
    a_wr_n = 1;
    tick();
    check("collide_new", 32'(b_q), 32'h55);

    // Blocked write during sweep, then accepted in first idle cycle
    idle_inputs(); clr_req = 1;
    tick();
    clr_req = 0;
    for (cnt = 0; busy && cnt < 40; cnt++) begin
      if (cnt == 2) begin a_ce_n = 0; a_wr_n = 0; a_addr = 4'd15; a_din = 8'hFF; end
      else idle_inputs();
      tick();
    end
    check("req_sweep_len", 32'(cnt), 32'd16);
    a_ce_n = 0; a_wr_n = 0; a_addr = 4'd15; a_din = 8'hFF; b_ce_n = 0; b_addr = 4'd15;
    tick();
    check("blocked_wr", 32'(b_q), 32'(FILLV));
    a_wr_n = 1;
    tick();
    check("first_idle_wr_a", 32'(a_q), 32'hFF);
    check("first_idle_wr_b", 32'(b_q), 32'hFF);

    // clr_req with same-cycle write is discarded; second request ignored
    a_addr = 4'd0; a_din = 8'h11; a_wr_n = 0;
    tick();
    a_din = 8'h22; clr_req = 1; b_addr = 4'd0;
    tick();
    check("req_rd_old", 32'(b_q), 32'h11);
    a_wr_n = 1; clr_req = 0;
    for (cnt = 0; busy && cnt < 40; cnt++) begin
      clr_req = (cnt == 4);
      tick();
      if (cnt == 0) check("req_wr_discarded", 32'(b_q), 32'h11);
    end
    clr_req = 0;
    check("req_ignored_len", 32'(cnt), 32'd16);

    // Reset mid-sweep restarts the full sweep
    for (int i = 0; i < 3; i++) begin
      a_addr = 4'(i + 4); a_din = 8'(8'h60 + i); a_wr_n = 0;
      tick();
    end
    a_wr_n = 1; clr_req = 1;
    tick();
    clr_req = 0;
    for (cnt = 0; cnt < 7; cnt++) tick();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    for (cnt = 0; busy && cnt < 40; cnt++) tick();
    check("rst_mid_len", 32'(cnt), 32'd16);

    // CLR_ON_RESET=0 instance
    tick(); tick();
    check("nr_reset_busy", 32'(r0_busy), 32'h0);
    r0_reset_n = 1;
    tick();
    check("nr_idle_busy", 32'(r0_busy), 32'h0);
    r0_a_ce_n = 0; r0_a_wr_n = 0;
    for (int i = 0; i < 16; i++) begin
      r0_a_addr = 4'(i); r0_a_din = 8'(8'h40 + i);
      tick();
    end
    r0_a_wr_n = 1; r0_clr_req = 1;
    tick();
    r0_clr_req = 0;
    check("nr_req_busy", 32'(r0_busy), 32'h1);
    for (cnt = 0; cnt < 7; cnt++) tick();
    r0_reset_n = 0;
    tick(); tick();
    r0_reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nr_stays_idle", 32'(r0_busy), 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      r0_a_addr = 4'(i);
      tick();
      if (i < 7) check("nr_cleared", 32'(r0_a_q), 32'(FILLV));
      else if (i > 7) check("nr_kept", 32'(r0_a_q), 32'(8'h40 + i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
